// File: rtl/ula_seq_if.sv
// Instruction handshake and write-back report between an instruction source and ula_sequenciador.
// instr transfers on a rising edge where instr_valid && instr_ready; done/result are a one-cycle write-back report.
interface ula_seq_if #(
  parameter int LARG = 4
);
  logic            instr_valid;
  logic            instr_ready;
  logic [8:0]      instr;
  logic            done;
  logic [LARG-1:0] result;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready,
    input  done,
    input  result
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready,
    output done,
    output result
  );
endinterface

// File: rtl/ula_sequenciador.sv
// Sequencer for the 4-bit ULA: accepts 9-bit instructions, reads two registers, runs one ULA op
// (or a load-immediate for op 3'b111) and writes the result back into a 4 x 4-bit register file.
module ula_sequenciador #(
  parameter int NREG = 4,
  parameter int LARG = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  ula_seq_if.slave        bus,
  output logic [2:0]      funcULA,
  output logic [LARG-1:0] A,
  output logic [LARG-1:0] B,
  input  logic [LARG-1:0] outULA,
  input  logic [1:0]      dbg_sel,
  output logic [LARG-1:0] dbg_data,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] OCIOSO  = 2'd0;
  localparam logic [1:0] EXEC    = 2'd1;
  localparam logic [1:0] ESCRITA = 2'd2;
  localparam logic [2:0] OP_LOAD = 3'b111;

  logic [1:0]      state;
  logic [1:0]      rd_q;
  logic [LARG-1:0] result_q;
  logic [LARG-1:0] regs [NREG];

  logic [2:0] op;
  logic [1:0] rd;
  logic [1:0] rs1;
  logic [1:0] rs2;

  assign op  = bus.instr[8:6];
  assign rd  = bus.instr[5:4];
  assign rs1 = bus.instr[3:2];
  assign rs2 = bus.instr[1:0];

  // Operands are read at acceptance; the previous write-back always finishes first, so no forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OCIOSO;
      rd_q     <= 2'd0;
      result_q <= '0;
      funcULA  <= 3'd0;
      A        <= '0;
      B        <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        OCIOSO: begin
          if (bus.instr_valid) begin
            rd_q <= rd;
            if (op == OP_LOAD) begin
              result_q <= bus.instr[LARG-1:0];
              state    <= ESCRITA;
            end else begin
              funcULA <= op;
              A       <= regs[rs1];
              B       <= regs[rs2];
              state   <= EXEC;
            end
          end
        end
        EXEC: begin
          result_q <= outULA;
          state    <= ESCRITA;
        end
        ESCRITA: begin
          regs[rd_q] <= result_q;
          state      <= OCIOSO;
        end
        default: state <= OCIOSO;
      endcase
    end
  end

  assign bus.instr_ready = (state == OCIOSO);
  assign bus.done        = (state == ESCRITA);
  assign bus.result      = result_q;
  assign dbg_data        = regs[dbg_sel];
  assign dbg_state       = state;

endmodule

// File: tb/tb_ula_sequenciador.sv
// Directed bench for ula_sequenciador with a behavioural 4-bit ULA attached to funcULA/A/B/outULA.
// ULA codes used here: 000 add, 001 sub, 010 and, 011 xor, 100 maior, 101 menor, 110 igual.
module tb_ula_sequenciador;

  logic       clk;
  logic       rst_n;
  logic [2:0] funcULA;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] outULA;
  logic [1:0] dbg_sel;
  logic [3:0] dbg_data;
  logic [1:0] dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  ula_seq_if #(.LARG(4)) bus ();

  ula_sequenciador #(.NREG(4), .LARG(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .funcULA   (funcULA),
    .A         (A),
    .B         (B),
    .outULA    (outULA),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    outULA = 4'd0;
    case (funcULA)
      3'b000: outULA = A + B;
      3'b001: outULA = A - B;
      3'b010: outULA = A & B;
      3'b011: outULA = A ^ B;
      3'b100: outULA = {3'b000, (A > B)};
      3'b101: outULA = {3'b000, (A < B)};
      3'b110: outULA = {3'b000, (A == B)};
      default: outULA = 4'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] sel, input logic [3:0] expv);
    @(negedge clk);
    dbg_sel = sel;
    #1;
    chk(tag, {28'd0, dbg_data}, {28'd0, expv});
  endtask

  // One instruction from an idle controller: checks EXEC operands (ULA ops) and the ESCRITA report.
  task automatic run(input string tag, input logic [8:0] ins,
                     input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] eres);
    @(negedge clk);
    chk({tag, ":ready"}, {31'd0, bus.instr_ready}, 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    if (ins[8:6] != 3'b111) begin
      @(negedge clk);
      chk({tag, ":exec_state"}, {30'd0, dbg_state}, 32'd1);
      chk({tag, ":exec_done"}, {31'd0, bus.done}, 32'd0);
      chk({tag, ":func"}, {29'd0, funcULA}, {29'd0, ins[8:6]});
      chk({tag, ":A"}, {28'd0, A}, {28'd0, ea});
      chk({tag, ":B"}, {28'd0, B}, {28'd0, eb});
    end
    @(negedge clk);
    chk({tag, ":done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, ":result"}, {28'd0, bus.result}, {28'd0, eres});
    chk({tag, ":ready_low"}, {31'd0, bus.instr_ready}, 32'd0);
  endtask

  logic [8:0] q_instr [3];
  logic [3:0] q_res   [3];

  initial begin
    rst_n           = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr       = 9'b000_00_01_10;
    dbg_sel         = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst:state", {30'd0, dbg_state}, 32'd0);
    chk("rst:ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("rst:done", {31'd0, bus.done}, 32'd0);
    chk("rst:result", {28'd0, bus.result}, 32'd0);
    chk("rst:func", {29'd0, funcULA}, 32'd0);
    chk("rst:A", {28'd0, A}, 32'd0);
    chk("rst:B", {28'd0, B}, 32'd0);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) chk_reg("rst:reg", r[1:0], 4'd0);

    run("load_r1", 9'b111_01_0101, 4'd0, 4'd0, 4'd5);
    run("load_r2", 9'b111_10_0011, 4'd0, 4'd0, 4'd3);
    chk_reg("r1_5", 2'd1, 4'd5);
    chk_reg("r2_3", 2'd2, 4'd3);

    run("add", 9'b000_00_01_10, 4'd5, 4'd3, 4'd8);
    chk_reg("r0_8", 2'd0, 4'd8);
    run("sub_wrap", 9'b001_11_10_01, 4'd3, 4'd5, 4'd14);
    chk_reg("r3_14", 2'd3, 4'd14);
    run("load_r1_9", 9'b111_01_1001, 4'd0, 4'd0, 4'd9);
    run("add_self", 9'b000_01_01_01, 4'd9, 4'd9, 4'd2);
    chk_reg("r1_2", 2'd1, 4'd2);

    run("reload_r1", 9'b111_01_1001, 4'd0, 4'd0, 4'd9);
    run("maior", 9'b100_00_01_10, 4'd9, 4'd3, 4'd1);
    run("menor", 9'b101_00_01_10, 4'd9, 4'd3, 4'd0);
    run("igual", 9'b110_00_01_10, 4'd9, 4'd3, 4'd0);
    run("igual_same", 9'b110_00_01_01, 4'd9, 4'd9, 4'd1);
    run("xor", 9'b011_00_01_10, 4'd9, 4'd3, 4'd10);
    run("and", 9'b010_00_01_10, 4'd9, 4'd3, 4'd1);
    chk_reg("r0_1", 2'd0, 4'd1);

    // instr_valid held high across three back-to-back instructions, the second depending on the first
    q_instr[0] = 9'b000_00_01_10; q_res[0] = 4'd12; // R0 = 9 + 3
    q_instr[1] = 9'b000_11_00_01; q_res[1] = 4'd5;  // R3 = 12 + 9
    q_instr[2] = 9'b001_10_11_10; q_res[2] = 4'd2;  // R2 = 5 - 3
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      bus.instr_valid = 1'b1;
      bus.instr       = q_instr[k / 3];
      chk("stream:ready", {31'd0, bus.instr_ready}, {31'd0, (k % 3) == 0});
      chk("stream:done", {31'd0, bus.done}, {31'd0, (k % 3) == 2});
      if ((k % 3) == 2) chk("stream:result", {28'd0, bus.result}, {28'd0, q_res[k / 3]});
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("stream:idle_ready", {31'd0, bus.instr_ready}, 32'd1);
    chk("stream:idle_done", {31'd0, bus.done}, 32'd0);
    chk_reg("stream:r0", 2'd0, 4'd12);
    chk_reg("stream:r3", 2'd3, 4'd5);
    chk_reg("stream:r2", 2'd2, 4'd2);
    chk_reg("stream:r1", 2'd1, 4'd9);

    // reset while an ADD is in EXEC
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr       = 9'b000_00_01_10;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("midrst:in_exec", {30'd0, dbg_state}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst:state", {30'd0, dbg_state}, 32'd0);
    chk("midrst:done", {31'd0, bus.done}, 32'd0);
    chk("midrst:result", {28'd0, bus.result}, 32'd0);
    chk("midrst:func", {29'd0, funcULA}, 32'd0);
    chk("midrst:A", {28'd0, A}, 32'd0);
    chk("midrst:B", {28'd0, B}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst:no_done", {31'd0, bus.done}, 32'd0);
      chk("midrst:ready", {31'd0, bus.instr_ready}, 32'd1);
    end
    for (int r = 0; r < 4; r++) chk_reg("midrst:reg", r[1:0], 4'd0);

    run("post_rst_load", 9'b111_10_0111, 4'd0, 4'd0, 4'd7);
    chk_reg("post_rst_r2", 2'd2, 4'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ula_sequenciador.md
Name: ula_sequenciador

Overview:
Controller that drives the 4-bit ULA's funcULA, A and B inputs and captures outULA. It accepts 9-bit instructions over a valid/ready handshake and holds a 4-entry x 4-bit register file (R0..R3). For each instruction it reads two operands, sequences one ULA operation and writes the result back. The spare ULA code 3'b111 serves as a load-immediate instruction.

Parameters:
NREG, 4, number of registers (fixed at 4; 2-bit register addresses)
LARG, 4, datapath width (must match ULA width)

Ports:
clk  in  1  clock, rising-edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present on instr
instr_ready  out  1  controller can accept; equals (state == OCIOSO)
instr  in  9  [8:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2; for op=111, [3:0] = imm
funcULA  out  3  ULA operation select, registered
A  out  4  ULA operand A, registered
B  out  4  ULA operand B, registered
outULA  in  4  combinational ULA result
done  out  1  one-cycle pulse in write-back cycle
result  out  4  value being written back; valid when done=1
dbg_sel  in  2  register-file debug read address
dbg_data  out  4  R[dbg_sel], combinational read

Behaviour:
- Reset (rst_n low, asynchronous): state=OCIOSO; R0..R3=0; funcULA=0, A=0, B=0, result_q=0, done=0. instr_valid is ignored while rst_n is low.
- States: OCIOSO, EXEC, ESCRITA.
- OCIOSO: instr_ready=1. On a clock edge with instr_valid=1, the instruction is accepted:
  - op≠111: register funcULA<=op, A<=R[rs1], B<=R[rs2], rd_q<=rd; go to EXEC.
  - op=111 (LOAD): result_q<=instr[3:0], rd_q<=rd; go to ESCRITA. funcULA, A and B keep their previous values.
- EXEC (1 cycle): funcULA, A and B are stable. At the closing edge, result_q<=outULA and the state moves to ESCRITA.
- ESCRITA (1 cycle): done=1, result=result_q. At the closing edge, R[rd_q]<=result_q and the state returns to OCIOSO.
- result always reflects result_q. It holds its value outside ESCRITA.
- instr_ready=0 in EXEC and ESCRITA. A held instr_valid is accepted on the first OCIOSO edge.
- Latency, ULA op: acceptance edge to register update is 3 edges, giving 1 instruction per 3 cycles. LOAD takes 2 edges.
- Operand reads happen at acceptance, after any prior write-back has completed, so no forwarding is needed. rs1=rs2 and rd=rs1/rs2 are legal.
- Arithmetic: 4-bit modular with no carry/borrow flag (the ULA wraps). Compare ops return 0 or 1 in bit 0.
- funcULA, A and B hold their last values in OCIOSO and ESCRITA; outULA is only sampled in EXEC.
- Reset mid-operation: the pending write is discarded and no done pulse occurs. The register file clears to 0.
- dbg_data shows a write-back on the cycle after the ESCRITA edge.

Test Plan:
- Reset, then LOAD R1=5 (instr=9'b111_01_0101) and LOAD R2=3 -> done pulses with result 5, then 3; dbg R1=5, R2=3.
- ADD R0=R1+R2 (9'b000_00_01_10) -> during EXEC funcULA=000, A=5, B=3. In ESCRITA done=1 and result=8. R0=8, 3 cycles after acceptance.
- SUB R3=R2-R1 (3-5) -> result=14 (wrap). LOAD R1=9 then ADD R1=R1+R1 -> result=2.
- MAIOR/MENOR/IGUAL with R1=9, R2=3 -> results 1/0/0. IGUAL R1,R1 -> 1. XOR 9^3=10, AND 9&3=1.
- instr_valid held high with 3 queued instructions -> instr_ready low in EXEC/ESCRITA. Exactly one acceptance per OCIOSO cycle and no instruction dropped or duplicated. A dependent ADD sees the prior result.
- Assert rst_n low during EXEC of an ADD -> done never pulses. R0..R3=0 and outputs are at reset values. After release, instr_ready=1.
